// File: rtl/lpif_align_pkg.sv
// Shared types and constants for the LPIF receive strobe/marker aligner.
package lpif_align_pkg;

    localparam int PHY_W      = 80;
    localparam int DATA_W     = 77;
    localparam int STROBE_LOC = 1;
    localparam int MARKER_LOC = 77;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } align_state_e;

endpackage

// File: rtl/lpif_align_fsm.sv
// Phase tracking, lock acquisition and lock-loss counting for the aligner.
module lpif_align_fsm
    import lpif_align_pkg::*;
#(
    parameter int STB_PERIOD = 8,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         online_i,
    input  logic         strobe_i,
    input  logic         marker_i,
    output logic         push_en_o,
    output align_state_e state_o,
    output logic [7:0]   err_cnt_o
);

    align_state_e state_q, state_d;
    logic [7:0]   phase_q, phase_d, phase_nxt;
    logic [3:0]   good_q, good_d;
    logic [3:0]   miss_q, miss_d;
    logic [7:0]   err_q, err_d;
    logic         exp_stb;
    logic         good_w;
    logic         loss;

    always_comb begin
        phase_nxt = (phase_q == 8'(STB_PERIOD - 1)) ? 8'd0 : phase_q + 8'd1;
        exp_stb   = (phase_nxt == 8'd0);
        good_w    = marker_i && (strobe_i == exp_stb);
        loss      = (state_q == ST_LOCKED) && !good_w
                    && ((miss_q + 4'd1) == 4'(LOSS_CNT));

        state_d   = state_q;
        phase_d   = phase_q;
        good_d    = good_q;
        miss_d    = miss_q;
        err_d     = err_q;
        push_en_o = 1'b0;

        // Loss is counted even when the link drops on the same cycle.
        if (loss && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (online_i) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (strobe_i && marker_i) begin
                    phase_d = 8'd0;
                    good_d  = 4'd1;
                    state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                phase_d = phase_nxt;
                if (!good_w) begin
                    good_d  = 4'd0;
                    state_d = ST_HUNT;
                end else if (strobe_i) begin
                    good_d = good_q + 4'd1;
                    if ((good_q + 4'd1) == 4'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                phase_d   = phase_nxt;
                push_en_o = marker_i && !loss;
                if (good_w) begin
                    miss_d = 4'd0;
                end else if (loss) begin
                    miss_d  = 4'd0;
                    good_d  = 4'd0;
                    state_d = ST_HUNT;
                end else begin
                    miss_d = miss_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!online_i) begin
            state_d   = ST_IDLE;
            phase_d   = 8'd0;
            good_d    = 4'd0;
            miss_d    = 4'd0;
            push_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= 8'd0;
            good_q  <= 4'd0;
            miss_q  <= 4'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign state_o   = state_q;
    assign err_cnt_o = err_q;

endmodule

// File: rtl/lpif_rx_strobe_marker_align.sv
// LPIF receive aligner top: payload extraction and registered outputs.
module lpif_rx_strobe_marker_align
    import lpif_align_pkg::*;
#(
    parameter int STB_PERIOD = 8,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 2
) (
    input  logic              clk_rd,
    input  logic              rst_rd,
    input  logic              rx_online,
    input  logic [PHY_W-1:0]  rx_phy0,
    output logic [DATA_W-1:0] rx_downstream_data,
    output logic              rx_downstream_push,
    output logic              align_done,
    output logic [7:0]        align_err_cnt,
    output logic [1:0]        align_state
);

    align_state_e      state;
    logic              push_en;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] data_q;
    logic              push_q;
    logic              unused_phy;

    lpif_align_fsm #(
        .STB_PERIOD(STB_PERIOD),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT)
    ) u_fsm (
        .clk_i    (clk_rd),
        .rst_i    (rst_rd),
        .online_i (rx_online),
        .strobe_i (rx_phy0[STROBE_LOC]),
        .marker_i (rx_phy0[MARKER_LOC]),
        .push_en_o(push_en),
        .state_o  (state),
        .err_cnt_o(align_err_cnt)
    );

    // Strobe and marker bits are stripped; bit 79 carries nothing.
    assign payload    = {rx_phy0[78], rx_phy0[76:2], rx_phy0[0]};
    assign unused_phy = rx_phy0[PHY_W-1];

    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            data_q <= '0;
            push_q <= 1'b0;
        end else begin
            push_q <= push_en;
            if (push_en) begin
                data_q <= payload;
            end
        end
    end

    assign rx_downstream_data = data_q;
    assign rx_downstream_push = push_q;
    assign align_done         = (state == ST_LOCKED);
    assign align_state        = state;

endmodule

// File: tb/tb_lpif_rx_strobe_marker_align.sv
// Scoreboard bench for lpif_rx_strobe_marker_align (default parameters).
module tb_lpif_rx_strobe_marker_align;

    logic        clk_rd = 1'b0;
    logic        rst_rd;
    logic        rx_online;
    logic [79:0] rx_phy0;
    logic [76:0] rx_downstream_data;
    logic        rx_downstream_push;
    logic        align_done;
    logic [7:0]  align_err_cnt;
    logic [1:0]  align_state;

    int          tests = 0;
    int          fails = 0;
    int          pos   = 0;
    int          err_exp = 0;
    logic [76:0] exp_q[$];
    logic [76:0] last_data = '0;

    lpif_rx_strobe_marker_align dut (
        .clk_rd            (clk_rd),
        .rst_rd            (rst_rd),
        .rx_online         (rx_online),
        .rx_phy0           (rx_phy0),
        .rx_downstream_data(rx_downstream_data),
        .rx_downstream_push(rx_downstream_push),
        .align_done        (align_done),
        .align_err_cnt     (align_err_cnt),
        .align_state       (align_state)
    );

    always #5 clk_rd = ~clk_rd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [76:0] model_payload(input logic [79:0] w);
        logic [76:0] p;
        p[0] = w[0];
        for (int k = 1; k <= 75; k++) p[k] = w[k+1];
        p[76] = w[78];
        return p;
    endfunction

    // One word per cycle; ep says whether the bench expects it pushed.
    task automatic drive(input logic stb, input logic mrk,
                         input logic onl, input logic ep);
        logic [79:0] w;
        logic [76:0] e;
        w = {16'($urandom()), $urandom(), $urandom()};
        w[1] = stb;
        w[77] = mrk;
        rx_phy0 = w;
        rx_online = onl;
        if (ep) exp_q.push_back(model_payload(w));
        @(posedge clk_rd);
        #1;
        pos++;
        tests++;
        if (rx_downstream_push) begin
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL push_unexpected: push=%b required 0 (pos %0d)",
                         rx_downstream_push, pos);
            end else begin
                e = exp_q.pop_front();
                if (rx_downstream_data !== e) begin
                    fails++;
                    $display("FAIL push_data: got %h required %h",
                             rx_downstream_data, e);
                end
                last_data = e;
            end
        end else begin
            if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                fails++;
                $display("FAIL push_missing: push=%b required 1 (pos %0d)",
                         rx_downstream_push, pos);
            end else if (rx_downstream_data !== last_data) begin
                fails++;
                $display("FAIL data_hold: got %h required %h",
                         rx_downstream_data, last_data);
            end
        end
    endtask

    task automatic locked_words(input int n);
        for (int i = 0; i < n; i++) drive(pos % 8 == 0, 1'b1, 1'b1, 1'b1);
    endtask

    // From HUNT: sync strobe then three more periods to LOCKED.
    task automatic hunt_lock();
        pos = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            drive(pos % 8 == 0, 1'b1, 1'b1, 1'b0);
            if (i == 23) begin
                tests++;
                if (align_state !== 2'd2) begin
                    fails++;
                    $display("FAIL hunt_lock_early: state=%0d required 2", align_state);
                end
            end
        end
        tests++;
        if (align_state !== 2'd3 || align_done !== 1'b1) begin
            fails++;
            $display("FAIL hunt_lock: state=%0d done=%b required 3/1",
                     align_state, align_done);
        end
    endtask

    // From IDLE: online with strobe on word 0, lock 32 cycles later.
    task automatic online_lock();
        pos = 0;
        for (int i = 0; i <= 32; i++) begin
            drive(pos % 8 == 0, 1'b1, 1'b1, 1'b0);
            if (i == 0) begin
                tests++;
                if (align_state !== 2'd1) begin
                    fails++;
                    $display("FAIL online_hunt: state=%0d required 1", align_state);
                end
            end
            if (i == 8) begin
                tests++;
                if (align_state !== 2'd2) begin
                    fails++;
                    $display("FAIL online_verify: state=%0d required 2", align_state);
                end
            end
            if (i == 31) begin
                tests++;
                if (align_done !== 1'b0 || align_state !== 2'd2) begin
                    fails++;
                    $display("FAIL lock_early: state=%0d done=%b required 2/0",
                             align_state, align_done);
                end
            end
        end
        tests++;
        if (align_state !== 2'd3 || align_done !== 1'b1) begin
            fails++;
            $display("FAIL lock_32: state=%0d done=%b required 3/1",
                     align_state, align_done);
        end
    endtask

    task automatic test_reset();
        rst_rd = 1'b1;
        rx_online = 1'b0;
        rx_phy0 = '0;
        repeat (3) @(posedge clk_rd);
        #1;
        tests++;
        if ({align_state, align_done, rx_downstream_push} !== 4'b0
            || rx_downstream_data !== '0 || align_err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: state=%0d done=%b push=%b data=%h err=%0d required all 0",
                     align_state, align_done, rx_downstream_push,
                     rx_downstream_data, align_err_cnt);
        end
        rst_rd = 1'b0;
        @(posedge clk_rd);
        #1;
        tests++;
        if (align_state !== 2'd0) begin
            fails++;
            $display("FAIL offline_idle: state=%0d required 0", align_state);
        end
    endtask

    task automatic test_lock();
        online_lock();
        locked_words(16);
    endtask

    task automatic test_miss();
        while (pos % 8 != 0) drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tests++;
        if (align_state !== 2'd3 || align_done !== 1'b1
            || align_err_cnt !== 8'(err_exp)) begin
            fails++;
            $display("FAIL single_miss: state=%0d done=%b err=%0d required 3/1/%0d",
                     align_state, align_done, align_err_cnt, err_exp);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tests++;
        if (align_state !== 2'd3) begin
            fails++;
            $display("FAIL miss_cleared: state=%0d required 3", align_state);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        err_exp++;
        tests++;
        if (align_state !== 2'd1 || align_done !== 1'b0
            || align_err_cnt !== 8'(err_exp)) begin
            fails++;
            $display("FAIL loss: state=%0d done=%b err=%0d required 1/0/%0d",
                     align_state, align_done, align_err_cnt, err_exp);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_verify_fail();
        logic seen_done;
        seen_done = 1'b0;
        pos = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            seen_done |= align_done;
        end
        tests++;
        if (align_state !== 2'd2) begin
            fails++;
            $display("FAIL verify_hold: state=%0d required 2", align_state);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        seen_done |= align_done;
        tests++;
        if (align_state !== 2'd1 || seen_done !== 1'b0) begin
            fails++;
            $display("FAIL verify_phase5: state=%0d done_seen=%b required 1/0",
                     align_state, seen_done);
        end
        hunt_lock();
    endtask

    task automatic test_offline();
        locked_words(3);
        drive(pos % 8 == 0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (align_state !== 2'd0 || align_done !== 1'b0
            || rx_downstream_push !== 1'b0 || align_err_cnt !== 8'(err_exp)) begin
            fails++;
            $display("FAIL offline: state=%0d done=%b push=%b err=%0d required 0/0/0/%0d",
                     align_state, align_done, rx_downstream_push,
                     align_err_cnt, err_exp);
        end
        online_lock();
        locked_words(4);
    endtask

    task automatic test_loss_offline();
        drive(pos % 8 != 0, 1'b1, 1'b1, 1'b1);
        drive(pos % 8 != 0, 1'b1, 1'b0, 1'b0);
        err_exp++;
        tests++;
        if (align_state !== 2'd0 || align_err_cnt !== 8'(err_exp)) begin
            fails++;
            $display("FAIL loss_offline: state=%0d err=%0d required 0/%0d",
                     align_state, align_err_cnt, err_exp);
        end
    endtask

    task automatic test_err_sat();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            hunt_lock();
            drive(pos % 8 != 0, 1'b1, 1'b1, 1'b1);
            drive(pos % 8 != 0, 1'b1, 1'b1, 1'b0);
            if (err_exp < 255) err_exp++;
            tests++;
            if (align_err_cnt !== 8'(err_exp) || align_state !== 2'd1) begin
                fails++;
                $display("FAIL err_count: loss %0d err=%0d state=%0d required %0d/1",
                         k, align_err_cnt, align_state, err_exp);
            end
        end
        tests++;
        if (align_err_cnt !== 8'd255) begin
            fails++;
            $display("FAIL err_sat: err=%0d required 255", align_err_cnt);
        end
    endtask

    task automatic test_reset_midlock();
        hunt_lock();
        locked_words(3);
        #3;
        rst_rd = 1'b1;
        #1;
        tests++;
        if (align_done !== 1'b0 || align_state !== 2'd0
            || rx_downstream_push !== 1'b0 || rx_downstream_data !== '0
            || align_err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_midlock: state=%0d done=%b push=%b data=%h err=%0d required all 0",
                     align_state, align_done, rx_downstream_push,
                     rx_downstream_data, align_err_cnt);
        end
        rx_online = 1'b0;
        @(posedge clk_rd);
        #1;
        rst_rd = 1'b0;
        exp_q.delete();
        last_data = '0;
        err_exp = 0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (align_state !== 2'd0 || align_err_cnt !== 8'd0) begin
            fails++;
            $display("FAIL post_reset: state=%0d err=%0d required 0/0",
                     align_state, align_err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_miss();
        test_verify_fail();
        test_offline();
        test_loss_offline();
        test_err_sat();
        test_reset_midlock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
